// File: rtl/mmio_arb_pkg.sv
// Shared types and bus widths for the MMIO bus arbiter.
package mmio_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  localparam int MMIO_ADDR_W = 21;
  localparam int MMIO_DATA_W = 32;

endpackage

// File: rtl/mmio_bus_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Round-robin sharing of the FPro MMIO bus between N_MST masters.
// Optional MMIO_ARB_LOCK_EN: a master may hold the bus across transactions.
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int N_MST  = 2,
  parameter int RD_LAT = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MST-1:0]             m_req,
  input  logic [N_MST-1:0]             m_wr,
  input  logic [N_MST*MMIO_ADDR_W-1:0] m_addr,
  input  logic [N_MST*MMIO_DATA_W-1:0] m_wr_data,
  input  logic [N_MST-1:0]             m_lock,
  output logic [N_MST-1:0]             m_gnt,
  output logic [N_MST-1:0]             m_done,
  output logic [MMIO_DATA_W-1:0]       m_rd_data,
  output logic                         mmio_cs,
  output logic                         mmio_wr,
  output logic                         mmio_rd,
  output logic [MMIO_ADDR_W-1:0]       mmio_addr,
  output logic [MMIO_DATA_W-1:0]       mmio_wr_data,
  input  logic [MMIO_DATA_W-1:0]       mmio_rd_data
);

  localparam int PW = (N_MST > 1) ? $clog2(N_MST) : 1;

  arb_state_t             state, state_n;
  logic [PW-1:0]          ptr, win_idx, own_idx, ptr_next;
  logic [N_MST-1:0]       arb_req, arb_gnt;
  logic                   arb_vld;
  logic                   cmd_wr;
  logic [MMIO_ADDR_W-1:0] cmd_addr;
  logic [MMIO_DATA_W-1:0] cmd_data;
  logic [2:0]             lat_cnt;

`ifdef MMIO_ARB_LOCK_EN
  logic          lock_vld;
  logic [PW-1:0] lock_owner;

  // A locked owner that is still requesting is the only candidate.
  always_comb begin
    arb_req = m_req;
    if (lock_vld && m_req[lock_owner])
      arb_req = N_MST'(1) << lock_owner;
  end
`else
  logic unused_lock;
  assign unused_lock = ^m_lock;
  assign arb_req     = m_req;
`endif

  rr_arbiter #(.N(N_MST), .PW(PW)) u_rr (
    .req (arb_req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .vld (arb_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < N_MST; k++)
      if (arb_gnt[k]) win_idx = PW'(k);
    ptr_next = (win_idx == PW'(N_MST - 1)) ? '0 : win_idx + PW'(1);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (arb_vld) state_n = ISSUE;
      ISSUE:   state_n = (cmd_wr || RD_LAT == 0) ? RESP : WAIT;
      WAIT:    if (lat_cnt == 3'd0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the bus view trails
  // the state by one cycle: strobes are visible in the cycle after ISSUE and
  // read data is sampled on the edge that leaves RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= '0;
      own_idx      <= '0;
      lat_cnt      <= '0;
      m_gnt        <= '0;
      m_done       <= '0;
      m_rd_data    <= '0;
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
`ifdef MMIO_ARB_LOCK_EN
      lock_vld     <= 1'b0;
      lock_owner   <= '0;
`endif
    end else begin
      state     <= state_n;
      m_gnt     <= '0;
      m_done    <= '0;
      m_rd_data <= '0;
      mmio_cs   <= 1'b0;
      mmio_wr   <= 1'b0;
      mmio_rd   <= 1'b0;
      case (state)
        IDLE: begin
`ifdef MMIO_ARB_LOCK_EN
          if (lock_vld && !m_req[lock_owner]) lock_vld <= 1'b0;
`endif
          if (arb_vld) begin
            m_gnt    <= arb_gnt;
            own_idx  <= win_idx;
            cmd_wr   <= m_wr[win_idx];
            cmd_addr <= m_addr[int'(win_idx)*MMIO_ADDR_W +: MMIO_ADDR_W];
            cmd_data <= m_wr_data[int'(win_idx)*MMIO_DATA_W +: MMIO_DATA_W];
            ptr      <= ptr_next;
`ifdef MMIO_ARB_LOCK_EN
            lock_vld   <= m_lock[win_idx];
            lock_owner <= win_idx;
            if (m_lock[win_idx]) ptr <= win_idx;
`endif
          end
        end
        ISSUE: begin
          mmio_cs      <= 1'b1;
          mmio_wr      <= cmd_wr;
          mmio_rd      <= !cmd_wr;
          mmio_addr    <= cmd_addr;
          mmio_wr_data <= cmd_data;
          lat_cnt      <= 3'(RD_LAT - 1);
        end
        WAIT: lat_cnt <= lat_cnt - 3'd1;
        RESP: begin
          m_done    <= N_MST'(1) << own_idx;
          m_rd_data <= cmd_wr ? '0 : mmio_rd_data;
        end
        default: ;
      endcase
    end
  end

endmodule
